display_ctrl: RTL and testbench



---
 rtl/display_ctrl.sv | 109 ++++++++++
 tb/tb_display_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_ctrl.sv
// Output register plus 4-digit common-anode seven-segment scanner for the 8-bit CPU "OUT" module.
// Optional macro DISPLAY_SIGNED_EN: show value as two's complement with a minus sign on digit3.
module display_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       cpu_clk,
    input  logic       enable,
    input  logic [7:0] bus,
    output logic [7:0] segments,
    output logic [3:0] digit
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    localparam logic [7:0] GLYPH_BLANK = 8'hFF;
    localparam logic [7:0] GLYPH_MINUS = 8'hBF;

    logic             cpu_clk_q_reg;
    logic [7:0]       value_reg;
    logic [CNT_W-1:0] count_reg;
    logic [1:0]       index_reg;
    logic [7:0]       segments_reg;
    logic [3:0]       digit_reg;

    logic             cpu_edge;
    logic [7:0]       magnitude;
    logic [3:0]       bcd [3];
    logic [7:0]       num_glyph [3];
    logic [7:0]       slot_glyph [4];

    function automatic logic [7:0] seg_glyph(input logic [3:0] d);
        case (d)
            4'd0:    seg_glyph = 8'hC0;
            4'd1:    seg_glyph = 8'hF9;
            4'd2:    seg_glyph = 8'hA4;
            4'd3:    seg_glyph = 8'hB0;
            4'd4:    seg_glyph = 8'h99;
            4'd5:    seg_glyph = 8'h92;
            4'd6:    seg_glyph = 8'h82;
            4'd7:    seg_glyph = 8'hF8;
            4'd8:    seg_glyph = 8'h80;
            4'd9:    seg_glyph = 8'h90;
            default: seg_glyph = GLYPH_BLANK;
        endcase
    endfunction

    assign cpu_edge = cpu_clk & ~cpu_clk_q_reg;

`ifdef DISPLAY_SIGNED_EN
    // -128 negates to 8'h80, which reads correctly as an unsigned 128.
    assign magnitude = value_reg[7] ? (~value_reg + 8'd1) : value_reg;
`else
    assign magnitude = value_reg;
`endif

    // Constant divisors on an 8-bit operand reduce to small fixed logic.
    assign bcd[0] = 4'(magnitude % 8'd10);
    assign bcd[1] = 4'((magnitude / 8'd10) % 8'd10);
    assign bcd[2] = 4'(magnitude / 8'd100);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_num
            assign num_glyph[gi] = seg_glyph(bcd[gi]);
        end
    endgenerate

    always_comb begin
        slot_glyph[0] = num_glyph[0];
        slot_glyph[1] = ((bcd[2] == 4'd0) && (bcd[1] == 4'd0)) ? GLYPH_BLANK : num_glyph[1];
        slot_glyph[2] = (bcd[2] == 4'd0) ? GLYPH_BLANK : num_glyph[2];
`ifdef DISPLAY_SIGNED_EN
        slot_glyph[3] = value_reg[7] ? GLYPH_MINUS : GLYPH_BLANK;
`else
        slot_glyph[3] = GLYPH_BLANK;
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cpu_clk_q_reg <= 1'b0;
            value_reg     <= 8'd0;
            count_reg     <= '0;
            index_reg     <= 2'd0;
            segments_reg  <= GLYPH_BLANK;
            digit_reg     <= 4'b1111;
        end else begin
            cpu_clk_q_reg <= cpu_clk;
            if (cpu_edge && enable) begin
                value_reg <= bus;
            end
            if (count_reg == CNT_MAX) begin
                count_reg <= '0;
                index_reg <= index_reg + 2'd1;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
            // Outputs are built from the current slot and value, so a load shows one edge later.
            digit_reg    <= ~(4'b0001 << index_reg);
            segments_reg <= slot_glyph[index_reg];
        end
    end

    assign segments = segments_reg;
    assign digit    = digit_reg;

endmodule

// File: tb/tb_display_ctrl.sv
// Bench for display_ctrl: table vectors per frame, hand sequences, and a random run
// checked every cycle against an arithmetic model of value, scan slot and glyphs.
module tb_display_ctrl;

    localparam int DIV = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_clk;
    logic       enable;
    logic [7:0] bus;
    logic [7:0] segments;
    logic [3:0] digit;

    int checks   = 0;
    int failures = 0;

    display_ctrl #(.REFRESH_DIV(DIV)) dut (
        .sys_clk (clk),
        .rst     (rst),
        .cpu_clk (cpu_clk),
        .enable  (enable),
        .bus     (bus),
        .segments(segments),
        .digit   (digit)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] GL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                       8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected glyph for display position idx when the output register holds v.
    function automatic logic [7:0] model_glyph(input logic [7:0] v, input int idx);
        int mag, h, t, o;
        bit neg;
`ifdef DISPLAY_SIGNED_EN
        neg = v[7];
        mag = neg ? 256 - int'(v) : int'(v);
`else
        neg = 1'b0;
        mag = int'(v);
`endif
        h = mag / 100;
        t = (mag / 10) % 10;
        o = mag % 10;
        case (idx)
            0:       model_glyph = GL[o];
            1:       model_glyph = (h == 0 && t == 0) ? 8'hFF : GL[t];
            2:       model_glyph = (h == 0) ? 8'hFF : GL[h];
            default: model_glyph = neg ? 8'hBF : 8'hFF;
        endcase
    endfunction

    // Reference model: cycles since reset release determine the slot shown.
    bit         mon_on = 1'b0;
    logic [7:0] m_val;
    logic       m_prev;
    int         m_cyc;
    logic [3:0] exp_digit;
    logic [7:0] exp_seg;

    always @(posedge clk) begin
        if (rst) begin
            m_val = 8'd0; m_prev = 1'b0; m_cyc = 0;
            exp_digit = 4'b1111; exp_seg = 8'hFF;
        end else begin
            exp_digit = ~(4'b0001 << ((m_cyc / DIV) % 4));
            exp_seg   = model_glyph(m_val, (m_cyc / DIV) % 4);
            if (cpu_clk && !m_prev && enable) m_val = bus;
            m_prev = cpu_clk;
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            check("mon_digit", {4'h0, digit}, {4'h0, exp_digit});
            check("mon_seg", segments, exp_seg);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [7:0] b, input logic e, input int rises);
        bus = b;
        enable = e;
        for (int r = 0; r < rises; r++) begin
            cpu_clk = 1'b1; cyc(); cyc();
            cpu_clk = 1'b0; cyc(); cyc();
        end
        enable = 1'b0;
    endtask

    // Collect one full frame of glyphs indexed by the active anode.
    task automatic capture(output logic [3:0][7:0] g);
        g = '0;
        for (int k = 0; k < 4 * DIV; k++) begin
            @(negedge clk);
            case (digit)
                4'b1110: g[0] = segments;
                4'b1101: g[1] = segments;
                4'b1011: g[2] = segments;
                4'b0111: g[3] = segments;
                default: ;
            endcase
        end
    endtask

    typedef struct {
        logic [7:0]       bus;
        logic             en;
        logic [3:0][7:0]  g;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] b, input logic e,
                                input logic [7:0] g0, input logic [7:0] g1,
                                input logic [7:0] g2, input logic [7:0] g3);
        vec_t v;
        v.bus = b; v.en = e;
        v.g[0] = g0; v.g[1] = g1; v.g[2] = g2; v.g[3] = g3;
        return v;
    endfunction

    vec_t vecs [8];
    logic [3:0][7:0] got;
    logic [3:0] rel_dig [8];
    logic [7:0] rel_seg [8];

    initial begin
        vecs[0] = mk(8'd123, 1'b1, 8'hB0, 8'hA4, 8'hF9, 8'hFF);
        vecs[1] = mk(8'd7,   1'b0, 8'hB0, 8'hA4, 8'hF9, 8'hFF);
        vecs[2] = mk(8'd5,   1'b1, 8'h92, 8'hFF, 8'hFF, 8'hFF);
`ifdef DISPLAY_SIGNED_EN
        vecs[3] = mk(8'd255, 1'b1, 8'hF9, 8'hFF, 8'hFF, 8'hBF);
        vecs[4] = mk(8'd200, 1'b1, 8'h82, 8'h92, 8'hFF, 8'hBF);
        vecs[7] = mk(8'd128, 1'b1, 8'h80, 8'hA4, 8'hF9, 8'hBF);
`else
        vecs[3] = mk(8'd255, 1'b1, 8'h92, 8'h92, 8'hA4, 8'hFF);
        vecs[4] = mk(8'd200, 1'b1, 8'hC0, 8'hC0, 8'hA4, 8'hFF);
        vecs[7] = mk(8'd128, 1'b1, 8'h80, 8'hA4, 8'hF9, 8'hFF);
`endif
        vecs[5] = mk(8'd10,  1'b1, 8'hC0, 8'hF9, 8'hFF, 8'hFF);
        vecs[6] = mk(8'd100, 1'b1, 8'hC0, 8'hC0, 8'hF9, 8'hFF);

        for (int k = 0; k < 8; k++) begin
            rel_dig[k] = ~(4'b0001 << (k / DIV));
            rel_seg[k] = (k / DIV == 0) ? 8'hC0 : 8'hFF;
        end

        rst = 1'b1; cpu_clk = 1'b0; enable = 1'b0; bus = 8'd0;
        cyc(); cyc();
        mon_on = 1'b1;
        cyc();
        check("reset_digit", {4'h0, digit}, 8'h0F);
        check("reset_seg", segments, 8'hFF);

        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("release_digit%0d", k), {4'h0, digit}, {4'h0, rel_dig[k]});
            check($sformatf("release_seg%0d", k), segments, rel_seg[k]);
        end

        for (int v = 0; v < 8; v++) begin
            cyc();
            apply(vecs[v].bus, vecs[v].en, vecs[v].en ? 1 : 3);
            cyc();
            capture(got);
            for (int i = 0; i < 4; i++)
                check($sformatf("vec%0d_slot%0d", v, i), got[i], vecs[v].g[i]);
            $display("vector %0d bus=%0d en=%0b glyphs=%02h %02h %02h %02h",
                     v, vecs[v].bus, vecs[v].en, got[3], got[2], got[1], got[0]);
        end

        // Held cpu_clk high: only the first rising sample loads.
        cyc();
        bus = 8'd42; enable = 1'b1; cpu_clk = 1'b1;
        cyc();
        bus = 8'd99;
        cyc(); cyc();
        cpu_clk = 1'b0; enable = 1'b0;
        cyc();
        capture(got);
        check("held_high_ones", got[0], model_glyph(8'd42, 0));
        check("held_high_tens", got[1], model_glyph(8'd42, 1));

        // Reset mid-frame after loading 200.
        cyc();
        apply(8'd200, 1'b1, 1);
        cyc();
        bus = 8'd77; enable = 1'b1; cpu_clk = 1'b1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_digit", {4'h0, digit}, 8'h0F);
        check("midrst_seg", segments, 8'hFF);
        rst = 1'b0; cpu_clk = 1'b0; enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("after_rst_digit", {4'h0, digit}, 8'h0E);
        check("after_rst_seg", segments, 8'hC0);
        capture(got);
        check("after_rst_tens", got[1], 8'hFF);
        check("after_rst_hund", got[2], 8'hFF);

        // Random traffic checked cycle by cycle by the monitor.
        cyc();
        for (int n = 0; n < 400; n++) begin
            bus     = 8'($urandom);
            enable  = 1'($urandom);
            cpu_clk = 1'($urandom);
            rst     = ($urandom_range(0, 39) == 0);
            cyc();
        end
        rst = 1'b0;
        repeat (4 * DIV + 2) cyc();
        mon_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
